// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU op scheduler: FSM states, operand/result widths, command record.
// The command struct uses the default tag width; the scheduler builds its own copy when TAG_W differs.
package alu_sched_pkg;

  localparam int OPND_W    = 5;
  localparam int RES_W     = 6;
  localparam int DEF_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                     sel;
    logic [2:0]               op;
    logic signed [OPND_W-1:0] a;
    logic signed [OPND_W-1:0] b;
    logic [DEF_TAG_W-1:0]     tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO, DEPTH (power of two) x W; pop data is the registered head, zero latency.
// Pushes are ignored while full and pops while empty; the caller watches full/empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  count;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign count   = wptr - rptr;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW + 1)'(1);
      if (pop && !empty) rptr <= rptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Queues ALU commands and issues one at a time; response appears ALU_LAT+3 cycles after accept when idle.
// cmd_ready falls when the queue is full; a stalled response blocks further issue. ALU_OP_SCHEDULER_OPCHK_EN adds rsp_err.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic signed [OPND_W-1:0] cmd_a,
  input  logic signed [OPND_W-1:0] cmd_b,
  input  logic                     cmd_sel,
  input  logic [2:0]               cmd_op,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic                     ALU_en,
  output logic                     a_en,
  output logic                     b_en,
  output logic [2:0]               a_op,
  output logic [1:0]               b_op,
  output logic signed [OPND_W-1:0] A,
  output logic signed [OPND_W-1:0] B,
  input  logic signed [RES_W-1:0]  alu_c,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic signed [RES_W-1:0]  rsp_c,
  output logic [TAG_W-1:0]         rsp_tag
`ifdef ALU_OP_SCHEDULER_OPCHK_EN
  , output logic                   rsp_err
`endif
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  // Same layout as alu_cmd_t but with the instance's tag width.
  typedef struct packed {
    logic                     sel;
    logic [2:0]               op;
    logic signed [OPND_W-1:0] a;
    logic signed [OPND_W-1:0] b;
    logic [TAG_W-1:0]         tag;
  } cmd_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  cmd_t             cmd_in;
  cmd_t             head;
  cmd_t             iss;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             illegal;

  assign cmd_ready = !rst && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign cmd_in    = '{sel: cmd_sel, op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
  assign rsp_valid = (state == RESP);

`ifdef ALU_OP_SCHEDULER_OPCHK_EN
  logic err_q;
  assign illegal = !head.sel && head.op[2];
  assign rsp_err = err_q && (state == RESP);
`else
  assign illegal = 1'b0;
`endif

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (cmd_in),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    ALU_en   = 1'b0;
    a_en     = 1'b0;
    b_en     = 1'b0;
    a_op     = '0;
    b_op     = '0;
    A        = '0;
    B        = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        ALU_en = 1'b1;
        A      = iss.a;
        B      = iss.b;
        if (iss.sel) begin
          a_en = 1'b1;
          a_op = iss.op;
        end else begin
          b_en = 1'b1;
          b_op = iss.op[1:0];
        end
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss     <= '0;
      cnt     <= '0;
      rsp_c   <= '0;
      rsp_tag <= '0;
    end else begin
      if (pop) begin
        iss <= head;
        // Rejected opcodes bypass the ALU and answer with a zero result.
        if (illegal) begin
          rsp_c   <= '0;
          rsp_tag <= head.tag;
        end
      end
      if (state == ISSUE) begin
        cnt <= CNT_W'(ALU_LAT - 1);
      end else if (state == WAIT) begin
        if (cnt == '0) begin
          rsp_c   <= alu_c;
          rsp_tag <= iss.tag;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

`ifdef ALU_OP_SCHEDULER_OPCHK_EN
  always_ff @(posedge clk) begin
    if (rst)      err_q <= 1'b0;
    else if (pop) err_q <= illegal;
  end
`endif

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Upstream stage of the 5-bit signed ALU: accepts operation commands over a valid/ready port, buffers them in a small FIFO, and issues them to the ALU one at a time with a single-cycle ALU_en pulse.
- Waits a fixed ALU latency, captures the 6-bit signed result c, and returns it with the command tag over a valid/ready response port.
- Only one operation is in flight at a time.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- ALU_LAT, 1, cycles from the ISSUE cycle to the edge that samples alu_c; at least 1.
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  5  signed operand A.
- cmd_b  in  5  signed operand B.
- cmd_sel  in  1  1 = A-group op (a_en/a_op), 0 = B-group op (b_en/b_op).
- cmd_op  in  3  opcode.
- cmd_tag  in  TAG_W  tag returned with the result.
- ALU_en  out  1  ALU enable; one-cycle pulse per operation.
- a_en  out  1  A-group select.
- b_en  out  1  B-group select.
- a_op  out  3  A-group opcode.
- b_op  out  2  B-group opcode (cmd_op[1:0]).
- A  out  5  signed operand to ALU.
- B  out  5  signed operand to ALU.
- alu_c  in  6  signed ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_c  out  6  signed captured result.
- rsp_tag  out  TAG_W  tag of the completed command.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; state IDLE; wait counter 0.
  - All outputs 0, including cmd_ready (cmd_ready is forced 0 while rst=1).
- Reset mid-operation: the in-flight op and all queued commands are discarded; no response is produced.
- Command push:
  - Occurs on a cycle with cmd_valid && cmd_ready.
  - cmd_ready = !full, derived from registered count only. A pop in the same cycle does not raise ready.
  - Push and pop in the same cycle is legal when the FIFO is neither full nor empty; count is unchanged.
  - Read/write pointers are log2(DEPTH) bits plus a wrap bit.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if FIFO is non-empty, pop the head into the issue register and go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle):
    - ALU_en=1; A=cmd_a; B=cmd_b.
    - cmd_sel=1: a_en=1, b_en=0, a_op=cmd_op, b_op=0.
    - cmd_sel=0: b_en=1, a_en=0, b_op=cmd_op[1:0], a_op=0.
    - Load wait counter with ALU_LAT-1, then go to WAIT.
  - WAIT: counter decrements each cycle. On the cycle the counter is 0, alu_c is sampled into rsp_c at that edge and the FSM goes to RESP.
    - With ALU_LAT=1, WAIT lasts one cycle: ISSUE at cycle n, sample at the end of n+1.
  - RESP:
    - rsp_valid=1; rsp_c and rsp_tag stay stable until rsp_ready=1.
    - On handshake: rsp_valid drops the next cycle and the FSM goes to IDLE.
- Issue-port outputs outside ISSUE: ALU_en, a_en, b_en, a_op, b_op, A and B are all 0.
- Latency, empty system, rsp_ready held high:
  - Command accepted at cycle t.
  - ISSUE at t+2.
  - rsp_valid at t+3+ALU_LAT.
- Back-pressure: commands keep filling the FIFO while RESP is stalled. Once full, cmd_ready=0 until the next pop.
- Widths: no arithmetic is done here. alu_c is captured unmodified as 6-bit two's complement.

Optional Feature:
- Macro ALU_OP_SCHEDULER_OPCHK_EN.
- Defined:
  - A popped command with cmd_sel=0 and cmd_op[2]=1 is illegal. It skips ISSUE/WAIT (no ALU_en pulse) and goes directly to RESP with rsp_c=0.
  - Extra output port rsp_err (1 bit) is 1 for that response and 0 otherwise; rsp_err resets to 0.
- Undefined: no rsp_err port; cmd_op[2] is silently dropped for B-group ops.

Decomposition:
- Package alu_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP).
  - Operand width 5 and result width 6 as localparams.
  - packed struct alu_cmd_t {sel, op, a, b, tag}. Its width depends on TAG_W, so the package struct uses the default TAG_W.
- One sub-module: alu_cmd_fifo.
  - Synchronous FIFO with count, full and empty.
  - Parameterised by DEPTH and data width.

Test Plan:
- Single A-op: cmd a=5'sd7, b=-5'sd3, sel=1, op=3'd2, tag=4'hA; ALU model returns 6'sd4 at ALU_LAT=1. Required: ALU_en high exactly at t+2 with a_en=1, b_en=0, a_op=2; then rsp_valid at t+4 with rsp_c=4, rsp_tag=A.
- Fill FIFO: push 5 back-to-back commands with rsp_ready=0. Required: 4 accepted plus 1 popped into issue; cmd_ready=0 once count=4; responses arrive in tag order 0..4 after rsp_ready rises.
- Response stall: hold rsp_ready=0 for 10 cycles in RESP. Required: rsp_c and rsp_tag stable; no second ALU_en pulse until the handshake.
- Negative result: B-op op=3'd1, a=-16, b=-16; model returns -6'sd32. Required: rsp_c=6'b100000, b_op=1.
- Reset mid-WAIT: assert rst for one cycle during WAIT with 2 commands queued. Required: next cycle all outputs 0, no rsp_valid, cmd_ready=1 after rst falls.
- OPCHK (macro defined): sel=0, op=3'd5. Required: no ALU_en pulse; rsp_valid with rsp_err=1, rsp_c=0.
